// File: rtl/axis_tx_fifo_pkg.sv
// Shared definitions for the axis_tx_fifo slice.
//   ptr_t    : wide pointer carrier; each user truncates to ADDR_W+1 bits
//   addr_w   : storage address width for a given DEPTH
//   ptr_inc  : pointer increment wrapping modulo 2*DEPTH (extra wrap bit kept)
package axis_tx_fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // DEPTH is a power of two, so modulo 2*DEPTH is a mask.
  function automatic ptr_t ptr_inc(input ptr_t ptr, input int unsigned depth);
    return (ptr + ptr_t'(1)) & (ptr_t'(2 * depth) - ptr_t'(1));
  endfunction

endpackage

// File: rtl/axis_tx_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of axis_tx_fifo.
//   tvalid : beat valid (master -> slave)
//   tdata  : beat payload, TDATA_WIDTH bits (master -> slave)
//   tready : slave accepts beat (slave -> master)
// Modports: master drives tvalid/tdata, slave drives tready.
interface axis_tx_fifo_if #(
  parameter int unsigned TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_tx_fifo_mem.sv
// Storage array for axis_tx_fifo: DEPTH x TDATA_WIDTH, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module axis_tx_fifo_mem
  import axis_tx_fifo_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = addr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [TDATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [TDATA_WIDTH-1:0] rdata
);

  logic [TDATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_tx_fifo.sv
// Producer-side elastic buffer: accepts beats on axis_sif and replays them in
// order on axis_mif from a DEPTH-entry circular queue. invalidate flushes
// every queued beat on the next edge.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   axis_sif   : producer side (slave modport)
//   axis_mif   : consumer side (master modport)
//   invalidate : synchronous flush; blocks push and pop in the same cycle
//   level      : occupancy 0..DEPTH, present only when AXIS_TX_FIFO_LEVEL_EN
//                is defined
module axis_tx_fifo
  import axis_tx_fifo_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  axis_tx_fifo_if.slave             axis_sif,
  axis_tx_fifo_if.master            axis_mif,
  input  logic                      invalidate
`ifdef AXIS_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]    level
`endif
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);

  typedef logic [ADDR_W:0] fptr_t;

  fptr_t                  wr_ptr;
  fptr_t                  rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [TDATA_WIDTH-1:0] rdata;

  // Flags come only from registered pointers, so a pop never opens tready
  // in the same cycle (no mif.tready -> sif.tready path).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign axis_sif.tready = !full && !invalidate && !rst;
  assign push            = axis_sif.tvalid && axis_sif.tready;

  assign axis_mif.tvalid = !empty && !invalidate;
  assign axis_mif.tdata  = rdata;
  assign pop             = axis_mif.tvalid && axis_mif.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (invalidate) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= fptr_t'(ptr_inc(ptr_t'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= fptr_t'(ptr_inc(ptr_t'(rd_ptr), DEPTH));
    end
  end

  axis_tx_fifo_mem #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (axis_sif.tdata),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

`ifdef AXIS_TX_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_axis_tx_fifo.sv
// Bench for axis_tx_fifo: three instances (DEPTH 4, 2, 8) share one stimulus
// stream; a cycle-level queue model per instance supplies expected values.
// Directed scenarios check the DEPTH=4 instance; the random scenario checks all.
module tb_axis_tx_fifo;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;
  logic        inv;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned mdepth [0:2] = '{4, 2, 8};
  logic [31:0] mq [0:2][$];

  logic        obs_v [0:2];
  logic        obs_r [0:2];
  logic [31:0] obs_d [0:2];

  axis_tx_fifo_if #(.TDATA_WIDTH(32)) sif0 ();
  axis_tx_fifo_if #(.TDATA_WIDTH(32)) mif0 ();
  axis_tx_fifo_if #(.TDATA_WIDTH(32)) sif1 ();
  axis_tx_fifo_if #(.TDATA_WIDTH(32)) mif1 ();
  axis_tx_fifo_if #(.TDATA_WIDTH(32)) sif2 ();
  axis_tx_fifo_if #(.TDATA_WIDTH(32)) mif2 ();

  assign sif0.tvalid = s_valid;  assign sif0.tdata = s_data;  assign mif0.tready = m_ready;
  assign sif1.tvalid = s_valid;  assign sif1.tdata = s_data;  assign mif1.tready = m_ready;
  assign sif2.tvalid = s_valid;  assign sif2.tdata = s_data;  assign mif2.tready = m_ready;

  assign obs_v[0] = mif0.tvalid;  assign obs_r[0] = sif0.tready;  assign obs_d[0] = mif0.tdata;
  assign obs_v[1] = mif1.tvalid;  assign obs_r[1] = sif1.tready;  assign obs_d[1] = mif1.tdata;
  assign obs_v[2] = mif2.tvalid;  assign obs_r[2] = sif2.tready;  assign obs_d[2] = mif2.tdata;

`ifdef AXIS_TX_FIFO_LEVEL_EN
  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic [3:0] lvl2;
  logic [3:0] obs_l [0:2];
  assign obs_l[0] = 4'(lvl0);
  assign obs_l[1] = 4'(lvl1);
  assign obs_l[2] = lvl2;
`endif

  axis_tx_fifo #(.TDATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .axis_sif(sif0), .axis_mif(mif0), .invalidate(inv)
`ifdef AXIS_TX_FIFO_LEVEL_EN
    , .level(lvl0)
`endif
  );

  axis_tx_fifo #(.TDATA_WIDTH(32), .DEPTH(2)) dut_d2 (
    .clk(clk), .rst(rst), .axis_sif(sif1), .axis_mif(mif1), .invalidate(inv)
`ifdef AXIS_TX_FIFO_LEVEL_EN
    , .level(lvl1)
`endif
  );

  axis_tx_fifo #(.TDATA_WIDTH(32), .DEPTH(8)) dut_d8 (
    .clk(clk), .rst(rst), .axis_sif(sif2), .axis_mif(mif2), .invalidate(inv)
`ifdef AXIS_TX_FIFO_LEVEL_EN
    , .level(lvl2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_v(input int k);
    return (mq[k].size() != 0) && !inv && !rst;
  endfunction

  function automatic bit exp_r(input int k);
    return (mq[k].size() < mdepth[k]) && !inv && !rst;
  endfunction

  // Advance one clock and apply the handshakes of the cycle just ended to the model.
  task automatic clk_step();
    bit do_push [0:2];
    bit do_pop  [0:2];
    for (int k = 0; k < 3; k++) begin
      do_pop[k]  = exp_v(k) && m_ready;
      do_push[k] = exp_r(k) && s_valid;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst || inv) begin
        mq[k].delete();
      end else begin
        if (do_pop[k])  void'(mq[k].pop_front());
        if (do_push[k]) mq[k].push_back(s_data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; inv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", obs_v[0]); end
    checks++; if (obs_r[0] !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", obs_r[0]); end
    clk_step();
    rst = 1'b0;
    clk_step();
    @(negedge clk);
    checks++; if (obs_r[0] !== 1'b1) begin errors++; $display("FAIL rel_tready: got %b want 1", obs_r[0]); end
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL rel_tvalid: got %b want 0", obs_v[0]); end
`ifdef AXIS_TX_FIFO_LEVEL_EN
    checks++; if (obs_l[0] !== 4'd0) begin errors++; $display("FAIL rel_level: got %0d want 0", obs_l[0]); end
`endif
    clk_step();
    // queue three beats, then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h10 + 32'(i);
      clk_step();
    end
    s_data = 32'h13; m_ready = 1'b1;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'h10) begin
      errors++; $display("FAIL pre_rst_head: got v=%b d=%h want v=1 d=00000010", obs_v[0], obs_d[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", obs_v[0]); end
    checks++; if (obs_r[0] !== 1'b0) begin errors++; $display("FAIL midrst_tready: got %b want 0", obs_r[0]); end
    clk_step();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    clk_step();
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL post_rst_empty: got %b want 0", obs_v[0]); end
    checks++; if (obs_r[0] !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %b want 1", obs_r[0]); end
`ifdef AXIS_TX_FIFO_LEVEL_EN
    checks++; if (obs_l[0] !== 4'd0) begin errors++; $display("FAIL post_rst_level: got %0d want 0", obs_l[0]); end
`endif
    clk_step();
  endtask

  task automatic test_order();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + 32'(i);
      @(negedge clk);
      checks++; if (obs_r[0] !== 1'b1) begin errors++; $display("FAIL order_fill_tready[%0d]: got %b want 1", i, obs_r[0]); end
      clk_step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (obs_r[0] !== 1'b0) begin errors++; $display("FAIL order_full_tready: got %b want 0", obs_r[0]); end
`ifdef AXIS_TX_FIFO_LEVEL_EN
    checks++; if (obs_l[0] !== 4'd4) begin errors++; $display("FAIL order_full_level: got %0d want 4", obs_l[0]); end
`endif
    clk_step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL order_out[%0d]: got v=%b d=%h want v=1 d=%h", i, obs_v[0], obs_d[0], 32'hA0 + 32'(i));
      end
      clk_step();
    end
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL order_drained: got %b want 0", obs_v[0]); end
    m_ready = 1'b0;
    clk_step();
  endtask

  task automatic test_full_pop();
    int unsigned pushed;
    int unsigned popped;
    int unsigned cyc;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + 32'(i);
      clk_step();
    end
    pushed = 4; popped = 0; cyc = 0;
    s_valid = 1'b1; s_data = 32'h104; m_ready = 1'b1;
    @(negedge clk);
    checks++; if (obs_r[0] !== 1'b0) begin errors++; $display("FAIL full_pop_tready_same: got %b want 0", obs_r[0]); end
    while (popped < 16 && cyc < 200) begin
      if (cyc != 0) begin
        s_valid = (pushed < 16);
        s_data  = 32'h100 + 32'(pushed);
        m_ready = ($urandom_range(2) != 0);
        @(negedge clk);
        if (cyc == 1) begin
          checks++; if (obs_r[0] !== 1'b1) begin errors++; $display("FAIL full_pop_tready_next: got %b want 1", obs_r[0]); end
        end
      end
      if (obs_v[0] && m_ready) begin
        checks++; if (obs_d[0] !== 32'h100 + 32'(popped)) begin
          errors++; $display("FAIL full_pop_data[%0d]: got %h want %h", popped, obs_d[0], 32'h100 + 32'(popped));
        end
        popped++;
      end
      if (s_valid && obs_r[0]) pushed++;
      clk_step();
      cyc++;
    end
    checks++; if (popped != 16) begin errors++; $display("FAIL full_pop_count: got %0d want 16", popped); end
    s_valid = 1'b0; m_ready = 1'b0;
    clk_step();
  endtask

  task automatic test_streaming();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      s_data = 32'(c);
      @(negedge clk);
      if (c == 0) begin
        checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL stream_first_latency: got %b want 0", obs_v[0]); end
      end else begin
        checks++; if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'(c - 1)) begin
          errors++; $display("FAIL stream_beat[%0d]: got v=%b d=%h want v=1 d=%h", c, obs_v[0], obs_d[0], 32'(c - 1));
        end
      end
      clk_step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'd99) begin
      errors++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=00000063", obs_v[0], obs_d[0]);
    end
    clk_step();
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", obs_v[0]); end
    m_ready = 1'b0;
    clk_step();
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h200 + 32'(i);
      clk_step();
    end
    s_valid = 1'b1; s_data = 32'hFF; inv = 1'b1;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL flush_tvalid: got %b want 0", obs_v[0]); end
    checks++; if (obs_r[0] !== 1'b0) begin errors++; $display("FAIL flush_tready: got %b want 0", obs_r[0]); end
    clk_step();
    inv = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", obs_v[0]); end
`ifdef AXIS_TX_FIFO_LEVEL_EN
    checks++; if (obs_l[0] !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", obs_l[0]); end
`endif
    clk_step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (obs_v[0] !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit[%0d]: got v=%b d=%h want v=0", i, obs_v[0], obs_d[0]);
      end
      clk_step();
    end
    s_valid = 1'b1; s_data = 32'h55;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL flush_refill_latency: got %b want 0", obs_v[0]); end
    clk_step();
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'h55) begin
      errors++; $display("FAIL flush_refill: got v=%b d=%h want v=1 d=00000055", obs_v[0], obs_d[0]);
    end
    clk_step();
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      s_valid = ($urandom_range(1) == 1);
      s_data  = $urandom;
      m_ready = ($urandom_range(1) == 1);
      inv     = ($urandom_range(99) < 5);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++; if (obs_v[k] !== exp_v(k)) begin
          errors++; $display("FAIL rand_tvalid d%0d cyc%0d: got %b want %b", mdepth[k], n, obs_v[k], exp_v(k));
        end
        checks++; if (obs_r[k] !== exp_r(k)) begin
          errors++; $display("FAIL rand_tready d%0d cyc%0d: got %b want %b", mdepth[k], n, obs_r[k], exp_r(k));
        end
        if (exp_v(k)) begin
          checks++; if (obs_d[k] !== mq[k][0]) begin
            errors++; $display("FAIL rand_tdata d%0d cyc%0d: got %h want %h", mdepth[k], n, obs_d[k], mq[k][0]);
          end
        end
`ifdef AXIS_TX_FIFO_LEVEL_EN
        checks++; if (obs_l[k] !== 4'(mq[k].size())) begin
          errors++; $display("FAIL rand_level d%0d cyc%0d: got %0d want %0d", mdepth[k], n, obs_l[k], mq[k].size());
        end
`endif
      end
      clk_step();
    end
    s_valid = 1'b0; m_ready = 1'b0; inv = 1'b0;
    clk_step();
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_pop();
    test_streaming();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
